// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings and sizes for the TLB op controller.
// Imported by the controller and its INVTLB match helper.
package tlb_op_ctrl_pkg;

  localparam int T_IDX_WID  = 4;
  localparam int TLBNUM_DEF = 16;
  localparam int IDX_W_DEF  = T_IDX_WID;

  localparam logic [2:0] TLB_OP_SRCH = 3'd0;
  localparam logic [2:0] TLB_OP_RD   = 3'd1;
  localparam logic [2:0] TLB_OP_WR   = 3'd2;
  localparam logic [2:0] TLB_OP_FILL = 3'd3;
  localparam logic [2:0] TLB_OP_INV  = 3'd4;

  localparam logic [4:0] INV_ALL0      = 5'd0;
  localparam logic [4:0] INV_ALL1      = 5'd1;
  localparam logic [4:0] INV_G         = 5'd2;
  localparam logic [4:0] INV_NG        = 5'd3;
  localparam logic [4:0] INV_NG_ASID   = 5'd4;
  localparam logic [4:0] INV_NG_ASV    = 5'd5;
  localparam logic [4:0] INV_GA_VA     = 5'd6;
  localparam logic [4:0] INV_OP_MAX    = 5'd6;

  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD,
    S_WR,
    S_INV,
    S_DONE
  } state_e;

endpackage

// File: rtl/tlb_op_ctrl_inv_match.sv
// Combinational INVTLB entry selector.
// Ignores the E bit; the caller qualifies with it.
module tlb_inv_match
  import tlb_op_ctrl_pkg::*;
(
  input  logic [4:0]  i_inv_op,
  input  logic [9:0]  i_inv_asid,
  input  logic [18:0] i_inv_vppn,
  input  logic        i_g,
  input  logic [5:0]  i_ps,
  input  logic [9:0]  i_asid,
  input  logic [18:0] i_vppn,
  output logic        o_match
);

  logic w_asid_m;
  logic w_va_m;

  assign w_asid_m = (i_asid == i_inv_asid);
  // 4MB pages only compare the bits above the page offset
  assign w_va_m = (i_ps == PS_4M)
    ? (i_vppn[18:9] == i_inv_vppn[18:9])
    : (i_vppn == i_inv_vppn);

  always_comb begin
    o_match = 1'b0;
    case (i_inv_op)
      INV_ALL0,
      INV_ALL1:    o_match = 1'b1;
      INV_G:       o_match = i_g;
      INV_NG:      o_match = ~i_g;
      INV_NG_ASID: o_match = ~i_g & w_asid_m;
      INV_NG_ASV:  o_match = ~i_g & w_asid_m & w_va_m;
      INV_GA_VA:   o_match = (i_g | w_asid_m) & w_va_m;
      default:     o_match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for retired TLB instructions and s1 port arbiter.
// INVTLB walks every entry through the read port, one per cycle.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vppn,
  output logic             op_ready,
  output logic             op_done,
  output logic             op_bad,
  output logic             refetch_req,
  input  logic [IDX_W-1:0] csr_tlbidx_index,
  input  logic [9:0]       csr_asid,
  input  logic [18:0]      csr_ehi_vppn,
  input  logic             mem_s_req,
  input  logic [18:0]      mem_s_vppn,
  input  logic             mem_s_va12,
  input  logic [9:0]       mem_s_asid,
  output logic             mem_s_gnt,
  output logic [18:0]      s1_vppn,
  output logic             s1_va12,
  output logic [9:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             tlbsrch_we,
  output logic             tlbsrch_hit,
  output logic [IDX_W-1:0] tlbsrch_hit_index,
  output logic             tlbrd_we,
  output logic [IDX_W-1:0] r_index,
  input  logic             r_e,
  input  logic             r_g,
  input  logic [5:0]       r_ps,
  input  logic [9:0]       r_asid,
  input  logic [18:0]      r_vppn,
  output logic             tlb_we,
  output logic [IDX_W-1:0] w_index,
  output logic             inv_clr_we,
  output logic [IDX_W-1:0] inv_clr_index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TLBNUM - 1);

  state_e           r_state;
  logic [4:0]       r_inv_op;
  logic [9:0]       r_inv_asid;
  logic [18:0]      r_inv_vppn;
  logic [IDX_W-1:0] r_w_idx;
  logic [IDX_W-1:0] r_fill_ctr;
  logic [IDX_W-1:0] r_walk;
  logic             r_bad;

  logic w_accept;
  logic w_srch;
  logic w_inv;
  logic w_match;

  assign w_accept = op_valid & (r_state == S_IDLE);
  assign w_srch   = (r_state == S_SRCH);
  assign w_inv    = (r_state == S_INV);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_w_idx    <= '0;
      r_fill_ctr <= '0;
      r_walk     <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_fill_ctr <= (r_fill_ctr == LAST) ? '0 : r_fill_ctr + 1'b1;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_inv_op   <= inv_op;
          r_inv_asid <= inv_asid;
          r_inv_vppn <= inv_vppn;
          r_w_idx    <= (op_code == TLB_OP_FILL)
                        ? r_fill_ctr : csr_tlbidx_index;
          case (op_code)
            TLB_OP_SRCH: r_state <= S_SRCH;
            TLB_OP_RD:   r_state <= S_RD;
            TLB_OP_WR,
            TLB_OP_FILL: r_state <= S_WR;
            TLB_OP_INV: begin
              if (inv_op <= INV_OP_MAX) begin
                r_state <= S_INV;
              end else begin
                r_state <= S_DONE;
                r_bad   <= 1'b1;
              end
            end
            default: begin
              r_state <= S_DONE;
              r_bad   <= 1'b1;
            end
          endcase
        end
        S_SRCH, S_RD, S_WR: r_state <= S_DONE;
        S_INV: begin
          if (r_walk == LAST) begin
            r_walk  <= '0;
            r_state <= S_DONE;
          end else begin
            r_walk <= r_walk + 1'b1;
          end
        end
        S_DONE: begin
          r_bad   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tlb_inv_match u_match (
    .i_inv_op   (r_inv_op),
    .i_inv_asid (r_inv_asid),
    .i_inv_vppn (r_inv_vppn),
    .i_g        (r_g),
    .i_ps       (r_ps),
    .i_asid     (r_asid),
    .i_vppn     (r_vppn),
    .o_match    (w_match)
  );

  assign op_ready    = (r_state == S_IDLE);
  assign op_done     = (r_state == S_DONE);
  assign op_bad      = op_done & r_bad;
  assign refetch_req = op_done & ~r_bad;

  // TLBSRCH steals s1 from the data side for its single cycle
  assign mem_s_gnt = mem_s_req & ~w_srch;
  assign s1_vppn   = w_srch ? csr_ehi_vppn : mem_s_vppn;
  assign s1_va12   = w_srch ? 1'b0 : mem_s_va12;
  assign s1_asid   = w_srch ? csr_asid : mem_s_asid;

  assign tlbsrch_we        = w_srch;
  assign tlbsrch_hit       = w_srch & s1_found;
  assign tlbsrch_hit_index = w_srch ? s1_index : '0;

  assign tlbrd_we = (r_state == S_RD);
  assign r_index  = w_inv ? r_walk : csr_tlbidx_index;

  assign tlb_we  = (r_state == S_WR);
  assign w_index = tlb_we ? r_w_idx : '0;

  assign inv_clr_we    = w_inv & r_e & w_match;
  assign inv_clr_index = w_inv ? r_walk : '0;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small TLB entry model.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        op_ready, op_done, op_bad, refetch_req;
  logic [3:0]  csr_tlbidx_index;
  logic [9:0]  csr_asid;
  logic [18:0] csr_ehi_vppn;
  logic        mem_s_req;
  logic [18:0] mem_s_vppn;
  logic        mem_s_va12;
  logic [9:0]  mem_s_asid;
  logic        mem_s_gnt;
  logic [18:0] s1_vppn;
  logic        s1_va12;
  logic [9:0]  s1_asid;
  logic        s1_found;
  logic [3:0]  s1_index;
  logic        tlbsrch_we, tlbsrch_hit;
  logic [3:0]  tlbsrch_hit_index;
  logic        tlbrd_we;
  logic [3:0]  r_index;
  logic        r_e, r_g;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic        tlb_we;
  logic [3:0]  w_index;
  logic        inv_clr_we;
  logic [3:0]  inv_clr_index;

  int checks = 0;
  int errors = 0;
  int fc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) fc <= 0;
    else fc <= (fc == 15) ? 0 : fc + 1;
  end

  // e2: live, non-global, asid 3, vppn hit
  // e5: global, otherwise like e2; e8: invalid
  // e11: 4MB page, low vppn bits differ but still matches
  always_comb begin
    r_e = 1'b1; r_g = 1'b0; r_ps = 6'd12;
    r_asid = 10'd1; r_vppn = 19'h00200;
    case (r_index)
      4'd2:  begin r_asid = 10'd3; r_vppn = 19'h00100; end
      4'd5:  begin r_g = 1'b1; r_asid = 10'd3; r_vppn = 19'h00100; end
      4'd8:  begin r_e = 1'b0; r_asid = 10'd3; r_vppn = 19'h00100; end
      4'd11: begin r_ps = 6'd21; r_asid = 10'd3; r_vppn = 19'h00105; end
      default: ;
    endcase
  end

  tlb_op_ctrl dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .op_ready(op_ready), .op_done(op_done), .op_bad(op_bad),
    .refetch_req(refetch_req),
    .csr_tlbidx_index(csr_tlbidx_index), .csr_asid(csr_asid),
    .csr_ehi_vppn(csr_ehi_vppn),
    .mem_s_req(mem_s_req), .mem_s_vppn(mem_s_vppn),
    .mem_s_va12(mem_s_va12), .mem_s_asid(mem_s_asid),
    .mem_s_gnt(mem_s_gnt),
    .s1_vppn(s1_vppn), .s1_va12(s1_va12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .tlbsrch_we(tlbsrch_we), .tlbsrch_hit(tlbsrch_hit),
    .tlbsrch_hit_index(tlbsrch_hit_index),
    .tlbrd_we(tlbrd_we), .r_index(r_index),
    .r_e(r_e), .r_g(r_g), .r_ps(r_ps), .r_asid(r_asid), .r_vppn(r_vppn),
    .tlb_we(tlb_we), .w_index(w_index),
    .inv_clr_we(inv_clr_we), .inv_clr_index(inv_clr_index)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk({tag, " pulses"},
        {28'd0, tlb_we, tlbrd_we, tlbsrch_we, inv_clr_we}, 32'd0);
  endtask

  task automatic issue(input logic [2:0] code, input logic [4:0] iop);
    op_code = code;
    inv_op = iop;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic run_inv(input logic [4:0] iop, input logic [15:0] mask);
    issue(3'd4, iop);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("inv%0d r_index k%0d", iop, k), r_index, k);
      chk($sformatf("inv%0d clr_we k%0d", iop, k), inv_clr_we, mask[k]);
      if (mask[k])
        chk($sformatf("inv%0d clr_idx k%0d", iop, k), inv_clr_index, k);
      chk($sformatf("inv%0d early done k%0d", iop, k), op_done, 0);
      step();
    end
    chk($sformatf("inv%0d done", iop), op_done, 1);
    chk($sformatf("inv%0d refetch", iop), refetch_req, 1);
    chk($sformatf("inv%0d clr after", iop), inv_clr_we, 0);
    step();
  endtask

  initial begin
    int n;
    reset = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0;
    inv_asid = 10'd3; inv_vppn = 19'h00100;
    csr_tlbidx_index = '0; csr_asid = '0; csr_ehi_vppn = '0;
    mem_s_req = 1'b0; mem_s_vppn = '0; mem_s_va12 = 1'b0; mem_s_asid = '0;
    s1_found = 1'b0; s1_index = '0;
    step(); step();
    chk("rst op_ready", op_ready, 1);
    chk("rst op_done", op_done, 0);
    quiet("rst");
    reset = 1'b0;

    mem_s_req = 1'b1; mem_s_vppn = 19'h12345; mem_s_asid = 10'd9;
    #1;
    chk("idle gnt", mem_s_gnt, 1);
    chk("idle s1_vppn", s1_vppn, 32'h12345);
    chk("idle s1_asid", s1_asid, 9);
    chk("idle ready", op_ready, 1);
    quiet("idle");

    csr_ehi_vppn = 19'h00ABC; csr_asid = 10'd5;
    s1_found = 1'b1; s1_index = 4'd7;
    issue(3'd0, 5'd0);
    chk("srch we", tlbsrch_we, 1);
    chk("srch hit", tlbsrch_hit, 1);
    chk("srch idx", tlbsrch_hit_index, 7);
    chk("srch gnt", mem_s_gnt, 0);
    chk("srch s1_vppn", s1_vppn, 32'h00ABC);
    chk("srch s1_asid", s1_asid, 5);
    chk("srch ready", op_ready, 0);
    step();
    chk("srch done", op_done, 1);
    chk("srch refetch", refetch_req, 1);
    chk("srch bad", op_bad, 0);
    chk("srch we off", tlbsrch_we, 0);
    step();
    chk("srch ready after", op_ready, 1);
    chk("srch done after", op_done, 0);

    csr_tlbidx_index = 4'd9;
    issue(3'd1, 5'd0);
    chk("rd we", tlbrd_we, 1);
    chk("rd r_index", r_index, 9);
    step();
    chk("rd done", op_done, 1);
    step();

    issue(3'd2, 5'd0);
    chk("wr we", tlb_we, 1);
    chk("wr w_index", w_index, 9);
    step();
    chk("wr done", op_done, 1);
    chk("wr we off", tlb_we, 0);
    step();

    n = 0;
    while (fc != 14 && n < 40) begin step(); n++; end
    chk("fill14 wait", n < 40, 1);
    issue(3'd3, 5'd0);
    chk("fill14 we", tlb_we, 1);
    chk("fill14 w_index", w_index, 14);
    step();
    chk("fill14 done", op_done, 1);
    step(); step();
    n = 0;
    while (fc != 3 && n < 40) begin step(); n++; end
    chk("fill3 wait", n < 40, 1);
    issue(3'd3, 5'd0);
    chk("fill3 w_index", w_index, 3);
    step();
    step();

    run_inv(5'd5, 16'h0804);
    run_inv(5'd2, 16'h0020);
    run_inv(5'd6, 16'h0824);
    run_inv(5'd3, 16'hFEDF);

    issue(3'd4, 5'd7);
    chk("badinv done", op_done, 1);
    chk("badinv bad", op_bad, 1);
    chk("badinv refetch", refetch_req, 0);
    quiet("badinv");
    step();
    chk("badinv ready", op_ready, 1);
    issue(3'd6, 5'd0);
    chk("badop done", op_done, 1);
    chk("badop bad", op_bad, 1);
    chk("badop refetch", refetch_req, 0);
    quiet("badop");
    step();

    issue(3'd4, 5'd0);
    repeat (6) step();
    chk("abort k6", r_index, 6);
    chk("abort k6 clr", inv_clr_we, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort ready", op_ready, 1);
    chk("abort clr", inv_clr_we, 0);
    chk("abort done", op_done, 0);
    csr_tlbidx_index = 4'd4;
    issue(3'd1, 5'd0);
    chk("post rd we", tlbrd_we, 1);
    chk("post rd idx", r_index, 4);
    step();
    chk("post rd done", op_done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
